reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
//  Write-side front end of the 16-entry register file: collects results from the ALU and load unit,
//  arbitrates them onto the single register-file write port (wr/wd/we), and tracks pending
//  destinations in a scoreboard for the issue stage. Sits between the execute/memory stages and
//  the register file. r0 and r15 are hardwired in the register file, so writes to them are consumed but never issued.
// PARAMETERS
//  width  16  data width of results and write port
//  DEPTH  4   load-result FIFO entries (power of 2, >=2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  alu_valid  in   1      ALU result present
//  alu_ready  out  1      ALU result accepted this cycle when alu_valid&alu_ready
//  alu_rd     in   4      ALU destination register
//  alu_data   in   width  ALU result
//  ld_valid   in   1      load result present
//  ld_ready   out  1      load result accepted when ld_valid&ld_ready
//  ld_rd      in   4      load destination register
//  ld_data    in   width  load result
//  pend_set   in   1      issue stage marks pend_rd as pending
//  pend_rd    in   4      register to mark pending
//  pend       out  16     scoreboard, bit n = write to rn outstanding
//  wr         out  4      register-file write address (registered)
//  wd         out  width  register-file write data (registered)
//  we         out  1      register-file write enable (registered)
//  rr1, rr2   in   4      register-file read addresses (bypass compare)
//  dr1_in, dr2_in   in   width  register-file read data
//  dr1_out, dr2_out out  width  read data to datapath (bypassed when enabled)
// BEHAVIOUR
//  - Reset (async, rst_n=0): we=0, wr=0, wd=0, pend=0, FIFO empty; after release ld_ready=1, alu_ready=1.
//  - Load path: accepted loads enter FIFO; ld_ready = !full. No same-cycle pass-through: min load latency
//    accept->we = 2 cycles. Push and pop in same cycle allowed when not full; count unchanged.
//  - ALU path: no storage; alu_ready = !full (combinational). Accepted ALU result drives we next cycle (latency 1).
//  - Arbitration per cycle: FIFO full -> pop FIFO head, ALU stalled; else alu_valid -> ALU; else FIFO
//    non-empty -> pop head; else idle (we=0 next cycle). Exactly one writer selected per cycle.
//  - Selected rd in {0,15}: entry consumed, we=0 next cycle (wr/wd hold previous values).
//    Otherwise next cycle we=1, wr=rd, wd=data. FIFO pointers wrap modulo DEPTH.
//  - Scoreboard: pend_set sets pend[pend_rd] for pend_rd not in {0,15}; bits 0 and 15 stay 0.
//    Bit cleared on the cycle we=1 with wr=n. Same-cycle set and clear of same bit -> set wins.
//  - Results write in acceptance/arbitration order; no reordering within the load FIFO.
//  - Reset mid-operation: FIFO contents and in-flight write discarded, we drops to 0 immediately.
// CONFIGURATION
//  WB_BYPASS_EN defined: drX_out = wd when we=1, wr==rrX and rrX not in {0,15}; else drX_in.
//    Covers the write-then-read hazard of the synchronous register-file write.
//  WB_BYPASS_EN undefined: drX_out = drX_in; rr1/rr2 unused. Ports exist in both builds.
// TESTING
//  1 Reset: assert rst_n=0 mid-stream with 3 loads queued -> we=0 at once, pend=0, ld_ready=1 after release.
//  2 ALU alu_rd=3, alu_data=16'h1234 single cycle -> next cycle we=1, wr=3, wd=16'h1234; pend[3] cleared.
//  3 4 loads rd=1..4 back-to-back with alu_valid held high (rd=5) -> FIFO fills, alu_ready=0,
//    loads drain in order 1,2,3,4 interleaved per rule; ld_ready=0 only while count==4.
//  4 ALU rd=0 data=16'hAAAA and load rd=15 -> both consumed, we never asserted.
//  5 pend_set rd=7 same cycle as we=1 wr=7 -> pend[7]=1 afterwards.
//  6 WB_BYPASS_EN: we=1 wr=9 wd=16'hBEEF, rr1=9, dr1_in=16'h0000 -> dr1_out=16'hBEEF; rr2=0 -> dr2_out=dr2_in;
//    without macro dr1_out=16'h0000.

Source files
------------

// File: rtl/reg_writeback.sv
// reg_writeback: write-side front end of the 16-entry register file.
// Collects ALU and load results, arbitrates them onto the single write
// port (wr/wd/we) and keeps the pending-destination scoreboard.
// Optional feature macro: WB_BYPASS_EN (write-to-read data bypass).
module reg_writeback #(
    parameter int width = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    output logic             alu_ready,
    input  logic [3:0]       alu_rd,
    input  logic [width-1:0] alu_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [3:0]       ld_rd,
    input  logic [width-1:0] ld_data,
    input  logic             pend_set,
    input  logic [3:0]       pend_rd,
    output logic [15:0]      pend,
    output logic [3:0]       wr,
    output logic [width-1:0] wd,
    output logic             we,
    input  logic [3:0]       rr1,
    input  logic [3:0]       rr2,
    input  logic [width-1:0] dr1_in,
    input  logic [width-1:0] dr2_in,
    output logic [width-1:0] dr1_out,
    output logic [width-1:0] dr2_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = width + 4;

    // Load FIFO: each entry holds {rd, data}
    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             full, empty, push, pop;

    // Arbitration result for this cycle
    logic             sel_vld;
    logic [3:0]       sel_rd;
    logic [width-1:0] sel_data;

    // Registered write port and scoreboard
    logic             we_q, we_d;
    logic [3:0]       wr_q, wr_d;
    logic [width-1:0] wd_q, wd_d;
    logic [15:0]      pend_q, pend_d;

    assign full      = (cnt_q == CW'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign ld_ready  = !full;
    assign alu_ready = !full;
    assign push      = ld_valid && !full;
    // A full FIFO always wins; otherwise the ALU has priority over queued loads.
    assign pop       = full || (!alu_valid && !empty);

    // Pick exactly one writer: FIFO head when popping, else the ALU result
    always_comb begin
        sel_vld  = 1'b0;
        sel_rd   = 4'd0;
        sel_data = '0;
        if (pop) begin
            sel_vld  = 1'b1;
            sel_rd   = mem_q[rptr_q][EW-1:width];
            sel_data = mem_q[rptr_q][width-1:0];
        end else if (alu_valid) begin
            sel_vld  = 1'b1;
            sel_rd   = alu_rd;
            sel_data = alu_data;
        end
    end

    // FIFO pointer and occupancy next state; pointers wrap modulo DEPTH
    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        cnt_d  = cnt_q;
        if (push) wptr_d = wptr_q + AW'(1);
        if (pop)  rptr_d = rptr_q + AW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Write port next state; r0/r15 are consumed silently and wr/wd hold
    always_comb begin
        we_d = 1'b0;
        wr_d = wr_q;
        wd_d = wd_q;
        if (sel_vld && (sel_rd != 4'd0) && (sel_rd != 4'd15)) begin
            we_d = 1'b1;
            wr_d = sel_rd;
            wd_d = sel_data;
        end
    end

    // Scoreboard: clear on the issued write, then a same-cycle set overrides it
    always_comb begin
        pend_d = pend_q;
        if (we_q) pend_d[wr_q] = 1'b0;
        if (pend_set && (pend_rd != 4'd0) && (pend_rd != 4'd15)) pend_d[pend_rd] = 1'b1;
        pend_d[0]  = 1'b0;
        pend_d[15] = 1'b0;
    end

    // Control and write-port registers; reset discards queued and in-flight writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            wr_q   <= 4'd0;
            wd_q   <= '0;
            pend_q <= '0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            wr_q   <= wr_d;
            wd_q   <= wd_d;
            pend_q <= pend_d;
        end
    end

    // FIFO storage; contents are meaningless while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {ld_rd, ld_data};
    end

    assign we   = we_q;
    assign wr   = wr_q;
    assign wd   = wd_q;
    assign pend = pend_q;

`ifdef WB_BYPASS_EN
    // Forward the write in flight to a same-address read (hardwired regs excluded)
    always_comb begin
        dr1_out = dr1_in;
        dr2_out = dr2_in;
        if (we_q && (wr_q == rr1) && (rr1 != 4'd0) && (rr1 != 4'd15)) dr1_out = wd_q;
        if (we_q && (wr_q == rr2) && (rr2 != 4'd0) && (rr2 != 4'd15)) dr2_out = wd_q;
    end
`else
    logic unused_rr;
    assign unused_rr = ^{rr1, rr2};
    assign dr1_out   = dr1_in;
    assign dr2_out   = dr2_in;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [3:0]  ld_rd;
    logic [15:0] ld_data;
    logic        pend_set;
    logic [3:0]  pend_rd;
    logic [15:0] pend;
    logic [3:0]  wr;
    logic [15:0] wd;
    logic        we;
    logic [3:0]  rr1, rr2;
    logic [15:0] dr1_in, dr2_in, dr1_out, dr2_out;

    int tests = 0;
    int fails = 0;

    reg_writeback #(.width(16), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .pend_set(pend_set), .pend_rd(pend_rd), .pend(pend),
        .wr(wr), .wd(wd), .we(we),
        .rr1(rr1), .rr2(rr2), .dr1_in(dr1_in), .dr2_in(dr2_in),
        .dr1_out(dr1_out), .dr2_out(dr2_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 16'h0;
        ld_valid  = 1'b0; ld_rd  = 4'd0; ld_data  = 16'h0;
        pend_set  = 1'b0; pend_rd = 4'd0;
        rr1 = 4'd0; rr2 = 4'd0; dr1_in = 16'h0; dr2_in = 16'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        tests++;
        if (we !== 1'b0 || wr !== 4'd0 || wd !== 16'h0 || pend !== 16'h0) begin
            fails++;
            $display("FAIL reset_state got we=%b wr=%0d wd=%h pend=%h exp 0/0/0000/0000", we, wr, wd, pend);
        end
        #2 rst_n = 1'b1;
        #1;
        tests++;
        if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got ld_ready=%b alu_ready=%b exp 1/1", ld_ready, alu_ready);
        end
        step();
    endtask

    task automatic test_alu();
        pend_set = 1'b1; pend_rd = 4'd3;
        step();
        pend_set = 1'b0;
        tests++;
        if (pend !== 16'h0008) begin
            fails++;
            $display("FAIL alu_pend_set got pend=%h exp 0008", pend);
        end
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h1234;
        step();
        alu_valid = 1'b0;
        tests++;
        if (we !== 1'b1 || wr !== 4'd3 || wd !== 16'h1234) begin
            fails++;
            $display("FAIL alu_write got we=%b wr=%0d wd=%h exp 1/3/1234", we, wr, wd);
        end
        step();
        tests++;
        if (pend !== 16'h0000 || we !== 1'b0) begin
            fails++;
            $display("FAIL alu_pend_clear got pend=%h we=%b exp 0000/0", pend, we);
        end
    endtask

    task automatic test_back_to_back();
        logic        in_ld_v   [10] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
        logic [3:0]  in_ld_rd  [10] = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
        logic        in_alu_v  [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic [15:0] in_alu_d  [10] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'hA004,
                                        16'hA004, 16'h0, 16'h0, 16'h0, 16'h0};
        logic        exp_rdy   [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        logic        exp_we    [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [3:0]  exp_wr    [10] = '{5, 5, 5, 5, 1, 5, 2, 3, 4, 4};
        logic [15:0] exp_wd    [10] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003, 16'h1001,
                                        16'hA004, 16'h1002, 16'h1003, 16'h1004, 16'h1004};
        for (int k = 0; k < 10; k++) begin
            ld_valid  = in_ld_v[k];
            ld_rd     = in_ld_rd[k];
            ld_data   = 16'h1000 + 16'(in_ld_rd[k]);
            alu_valid = in_alu_v[k];
            alu_rd    = 4'd5;
            alu_data  = in_alu_d[k];
            #1;
            tests++;
            if (ld_ready !== exp_rdy[k] || alu_ready !== exp_rdy[k]) begin
                fails++;
                $display("FAIL b2b_ready[%0d] got ld_ready=%b alu_ready=%b exp %b", k, ld_ready, alu_ready, exp_rdy[k]);
            end
            @(posedge clk);
            #1;
            tests++;
            if (we !== exp_we[k] || wr !== exp_wr[k] || wd !== exp_wd[k]) begin
                fails++;
                $display("FAIL b2b_write[%0d] got we=%b wr=%0d wd=%h exp %b/%0d/%h",
                         k, we, wr, wd, exp_we[k], exp_wr[k], exp_wd[k]);
            end
        end
        idle_inputs();
    endtask

    task automatic test_r0_r15();
        alu_valid = 1'b1; alu_rd = 4'd2; alu_data = 16'h5555;
        step();
        tests++;
        if (we !== 1'b1 || wr !== 4'd2 || wd !== 16'h5555) begin
            fails++;
            $display("FAIL r0r15_pre got we=%b wr=%0d wd=%h exp 1/2/5555", we, wr, wd);
        end
        alu_rd = 4'd0; alu_data = 16'hAAAA;
        ld_valid = 1'b1; ld_rd = 4'd15; ld_data = 16'h1111;
        for (int k = 0; k < 3; k++) begin
            step();
            idle_inputs();
            tests++;
            if (we !== 1'b0 || wr !== 4'd2 || wd !== 16'h5555) begin
                fails++;
                $display("FAIL r0r15_hold[%0d] got we=%b wr=%0d wd=%h exp 0/2/5555", k, we, wr, wd);
            end
        end
        tests++;
        if (ld_ready !== 1'b1) begin
            fails++;
            $display("FAIL r0r15_drained got ld_ready=%b exp 1", ld_ready);
        end
    endtask

    task automatic test_pend();
        pend_set = 1'b1; pend_rd = 4'd7;
        step();
        pend_set = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd7; alu_data = 16'h7777;
        step();
        alu_valid = 1'b0;
        tests++;
        if (we !== 1'b1 || wr !== 4'd7) begin
            fails++;
            $display("FAIL pend_write got we=%b wr=%0d exp 1/7", we, wr);
        end
        pend_set = 1'b1; pend_rd = 4'd7;
        step();
        tests++;
        if (pend !== 16'h0080) begin
            fails++;
            $display("FAIL pend_set_wins got pend=%h exp 0080", pend);
        end
        pend_rd = 4'd0;
        step();
        pend_rd = 4'd15;
        step();
        pend_set = 1'b0;
        tests++;
        if (pend !== 16'h0080) begin
            fails++;
            $display("FAIL pend_hardwired got pend=%h exp 0080", pend);
        end
    endtask

    task automatic test_bypass();
        logic [15:0] exp1;
`ifdef WB_BYPASS_EN
        exp1 = 16'hBEEF;
`else
        exp1 = 16'h0000;
`endif
        alu_valid = 1'b1; alu_rd = 4'd9; alu_data = 16'hBEEF;
        step();
        alu_valid = 1'b0;
        rr1 = 4'd9; dr1_in = 16'h0000;
        rr2 = 4'd0; dr2_in = 16'h1357;
        #1;
        tests++;
        if (we !== 1'b1 || dr1_out !== exp1) begin
            fails++;
            $display("FAIL bypass_hit got we=%b dr1_out=%h exp 1/%h", we, dr1_out, exp1);
        end
        tests++;
        if (dr2_out !== 16'h1357) begin
            fails++;
            $display("FAIL bypass_r0 got dr2_out=%h exp 1357", dr2_out);
        end
        step();
        dr1_in = 16'h2468;
        #1;
        tests++;
        if (we !== 1'b0 || dr1_out !== 16'h2468) begin
            fails++;
            $display("FAIL bypass_idle got we=%b dr1_out=%h exp 0/2468", we, dr1_out);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 16'h6666;
        pend_set = 1'b1; pend_rd = 4'd8;
        for (int k = 1; k <= 3; k++) begin
            ld_valid = 1'b1; ld_rd = 4'(k); ld_data = 16'h2000 + 16'(k);
            step();
            pend_set = 1'b0;
        end
        ld_valid = 1'b0;
        tests++;
        if (we !== 1'b1 || wr !== 4'd6 || pend !== 16'h0180) begin
            fails++;
            $display("FAIL midrst_pre got we=%b wr=%0d pend=%h exp 1/6/0180", we, wr, pend);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (we !== 1'b0 || pend !== 16'h0 || wr !== 4'd0 || wd !== 16'h0) begin
            fails++;
            $display("FAIL midrst_async got we=%b pend=%h wr=%0d wd=%h exp 0/0000/0/0000", we, pend, wr, wd);
        end
        idle_inputs();
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        tests++;
        if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_ready got ld_ready=%b alu_ready=%b exp 1/1", ld_ready, alu_ready);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            tests++;
            if (we !== 1'b0) begin
                fails++;
                $display("FAIL midrst_discard[%0d] got we=%b wr=%0d exp we=0", k, we, wr);
            end
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alu();
        test_back_to_back();
        test_r0_r15();
        test_pend();
        test_bypass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
